// File: rtl/data_mem_resp_pkg.sv
// Shared opcodes header for the data-memory responder: MEM-stage control codes,
// FSM state encodings and the default access latency.
package data_mem_resp_pkg;

  typedef logic [3:0] ctrl_t;

  localparam ctrl_t Ctrl_NOP = 4'h0;
  localparam ctrl_t Ctrl_ADD = 4'h1;
  localparam ctrl_t Ctrl_SUB = 4'h2;
  localparam ctrl_t Ctrl_AND = 4'h3;
  localparam ctrl_t Ctrl_OR  = 4'h4;
  localparam ctrl_t Ctrl_SLT = 4'h5;
  localparam ctrl_t Ctrl_LW  = 4'h8;
  localparam ctrl_t Ctrl_SW  = 4'h9;
  localparam ctrl_t Ctrl_BEQ = 4'hA;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DMEM_DEFAULT_LATENCY = 2;

  function automatic logic is_mem_req(input ctrl_t ctrl);
    return (ctrl == Ctrl_LW) || (ctrl == Ctrl_SW);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit data storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_resp.sv
// MEM-stage data memory with a multi-cycle IDLE/BUSY/DONE handshake that freezes the pipeline.
// Define DMEM_ZERO_WAIT_EN to build a single-cycle memory with no stall instead.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = DMEM_DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  control_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        ack_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             req;
  logic             req_is_sw;
  logic [IDX_W-1:0] addr_idx;
  logic             arr_we;
  logic [IDX_W-1:0] arr_waddr;
  logic [IDX_W-1:0] arr_raddr;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;
  logic             unused_addr;

  assign req         = is_mem_req(control_i);
  assign req_is_sw   = (control_i == Ctrl_SW);
  // Word index only; upper address bits wrap and the byte offset is ignored.
  assign addr_idx    = addr_i[IDX_W+1:2];
  assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

`ifdef DMEM_ZERO_WAIT_EN

  logic unused_rst;

  assign unused_rst = rst_i;
  assign arr_we     = req && req_is_sw;
  assign arr_waddr  = addr_idx;
  assign arr_wdata  = wdata_i;
  assign arr_raddr  = addr_idx;
  assign rdata_o    = arr_rdata;
  assign stall_o    = 1'b0;
  assign ack_o      = req;

`else

  logic [1:0]       state;
  logic [3:0]       count;
  logic             op_sw;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  // The request is latched in IDLE because the pipeline keeps it frozen only
  // while stall_o is high; DONE ignores control_i since EX/MEM still holds it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      count   <= '0;
      op_sw   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_sw   <= req_is_sw;
            idx_q   <= addr_idx;
            wdata_q <= wdata_i;
            count   <= 4'(LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (count == 4'd0) begin
            if (!op_sw) begin
              rdata_o <= arr_rdata;
            end
            state <= ST_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arr_we    = (state == ST_BUSY) && (count == 4'd0) && op_sw;
  assign arr_waddr = idx_q;
  assign arr_wdata = wdata_q;
  assign arr_raddr = idx_q;

  // Reset must drop the freeze request at once, even if a request is on control_i.
  assign stall_o = !rst_i && (((state == ST_IDLE) && req) || (state == ST_BUSY));
  assign ack_o   = (state == ST_DONE);

`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (DEPTH=32, LATENCY=2) using a
// transaction-level memory model: every access is LATENCY+1 stall cycles, then one ack cycle.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  localparam int DEPTH   = 32;
  localparam int LATENCY = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  control_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        ack_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  logic [31:0] pre_reset_word1;

  data_mem_resp #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .control_i (control_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .stall_o   (stall_o),
    .ack_o     (ack_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata);
    control_i = ctrl;
    addr_i    = addr;
    wdata_i   = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic stall_exp, input logic ack_exp);
    checkOutput({tag, ".stall"}, {31'b0, stall_o}, {31'b0, stall_exp});
    checkOutput({tag, ".ack"},   {31'b0, ack_o},   {31'b0, ack_exp});
    checkOutput({tag, ".rdata"}, rdata_o, model_rdata);
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // One complete access, inputs held through DONE as the frozen pipeline would.
  task automatic doAccess(input string tag, input logic [3:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata);
    applyStimulus(ctrl, addr, wdata);
    for (int c = 0; c < LATENCY + 1; c++) begin
      #2 checkAll($sformatf("%s.stall%0d", tag, c), 1'b1, 1'b0);
      nextCycle();
    end
    if (ctrl == Ctrl_SW) model_mem[word_of(addr)] = wdata;
    else                 model_rdata = model_mem[word_of(addr)];
    #2 checkAll($sformatf("%s.done", tag), 1'b0, 1'b1);
    nextCycle();
  endtask

  task automatic idleCycle(input string tag, input logic [3:0] ctrl);
    applyStimulus(ctrl, $urandom, $urandom);
    #2 checkAll(tag, 1'b0, 1'b0);
    nextCycle();
  endtask

  initial begin
    logic [3:0] other;
    model_rdata = '0;
    rst_i = 1'b1;
    applyStimulus(Ctrl_SW, 32'h8, 32'h1);
    nextCycle();
    nextCycle();
    #2 checkAll("reset", 1'b0, 1'b0);
    applyStimulus(Ctrl_NOP, '0, '0);
    rst_i = 1'b0;
    nextCycle();
    idleCycle("post_reset_idle", Ctrl_NOP);

    $display("[TB] store/load basics");
    doAccess("sw_08", Ctrl_SW, 32'h08, 32'hDEADBEEF);
    doAccess("lw_08", Ctrl_LW, 32'h08, 32'h0);
    doAccess("sw_80", Ctrl_SW, 32'h80, 32'h00001234);
    doAccess("lw_00_wrap", Ctrl_LW, 32'h00, 32'h0);

    $display("[TB] preload all words");
    for (int w = 0; w < DEPTH; w++) begin
      doAccess($sformatf("preload%0d", w), Ctrl_SW, (32'(w) << 2) | 32'($urandom_range(0, 3)),
               $urandom);
    end
    pre_reset_word1 = model_mem[1];

    $display("[TB] reset during a store");
    applyStimulus(Ctrl_SW, 32'h04, 32'h55);
    #2 checkAll("rst_sw.req", 1'b1, 1'b0);
    nextCycle();
    #2 checkAll("rst_sw.busy", 1'b1, 1'b0);
    rst_i = 1'b1;
    model_rdata = '0;
    #1 checkAll("rst_sw.async", 1'b0, 1'b0);
    nextCycle();
    #2 checkAll("rst_sw.held", 1'b0, 1'b0);
    applyStimulus(Ctrl_NOP, '0, '0);
    rst_i = 1'b0;
    nextCycle();
    idleCycle("rst_sw.idle", Ctrl_NOP);
    doAccess("lw_04_after_rst", Ctrl_LW, 32'h04, 32'h0);
    checkOutput("lw_04_pre_reset_value", rdata_o, pre_reset_word1);

    $display("[TB] non-memory stream");
    for (int i = 0; i < 8; i++) begin
      idleCycle($sformatf("nop_beq%0d", i), (i % 2 == 0) ? Ctrl_NOP : Ctrl_BEQ);
    end

    $display("[TB] back-to-back loads");
    doAccess("b2b_lw_08", Ctrl_LW, 32'h08, 32'h0);
    doAccess("b2b_lw_0c", Ctrl_LW, 32'h0C, 32'h0);
    idleCycle("b2b_after", Ctrl_NOP);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1: doAccess($sformatf("rnd%0d_lw", i), Ctrl_LW, $urandom, $urandom);
        2, 3: doAccess($sformatf("rnd%0d_sw", i), Ctrl_SW, $urandom, $urandom);
        default: begin
          other = 4'($urandom_range(0, 13));
          if (other >= Ctrl_LW) other = other + 4'd2;
          idleCycle($sformatf("rnd%0d_other", i), other);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
